// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator: compares one W-bit chunk per cycle, MSB chunk first.
// Optional early exit on first differing chunk: define COMPARATOR_SEQ_EARLY_EXIT_EN.
module comparator_seq #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         equals,
  output logic         less_than,
  output logic         greater_than
);

  localparam int C  = N / W;
  localparam int CW = (C > 1) ? $clog2(C) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(C - 1);
  localparam logic [W-1:0]  MSB_MASK = W'(1) << (W - 1);

  if (N % W != 0) begin : g_bad_width
    $error("comparator_seq: N must be a multiple of W");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t         state_r;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic           signed_r;
  logic [CW-1:0]  idx_r;
  logic           decided_r;
  logic           lt_r;
  logic           gt_r;

  logic [W-1:0]   ca_s;
  logic [W-1:0]   cb_s;
  logic           flip_s;
  logic           chunk_lt_s;
  logic           chunk_gt_s;
  logic           diff_s;
  logic           res_lt_s;
  logic           res_gt_s;
  logic           exit_s;

  function automatic logic [W-1:0] chunk_of(input logic [N-1:0] v, input logic [CW-1:0] idx);
    logic [N-1:0] sh;
    sh = v >> (int'(idx) * W);
    return sh[W-1:0];
  endfunction

  // Current chunk compare; the top chunk's sign bit is flipped so signed order becomes unsigned order.
  always_comb begin
    flip_s     = signed_r & (idx_r == LAST_IDX);
    ca_s       = chunk_of(a_r, idx_r) ^ (flip_s ? MSB_MASK : {W{1'b0}});
    cb_s       = chunk_of(b_r, idx_r) ^ (flip_s ? MSB_MASK : {W{1'b0}});
    chunk_lt_s = (ca_s < cb_s);
    chunk_gt_s = (ca_s > cb_s);
    diff_s     = chunk_lt_s | chunk_gt_s;
    res_lt_s   = decided_r ? lt_r : chunk_lt_s;
    res_gt_s   = decided_r ? gt_r : chunk_gt_s;
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    exit_s     = (idx_r == {CW{1'b0}}) | diff_s;
`else
    exit_s     = (idx_r == {CW{1'b0}});
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      a_r          <= {N{1'b0}};
      b_r          <= {N{1'b0}};
      signed_r     <= 1'b0;
      idx_r        <= {CW{1'b0}};
      decided_r    <= 1'b0;
      lt_r         <= 1'b0;
      gt_r         <= 1'b0;
      o_ready      <= 1'b1;
      o_valid      <= 1'b0;
      equals       <= 1'b0;
      less_than    <= 1'b0;
      greater_than <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid && o_ready) begin
            a_r       <= a;
            b_r       <= b;
            signed_r  <= signed_mode;
            idx_r     <= LAST_IDX;
            decided_r <= 1'b0;
            lt_r      <= 1'b0;
            gt_r      <= 1'b0;
            o_ready   <= 1'b0;
            state_r   <= COMPARE;
          end
        end
        COMPARE: begin
          if (!decided_r && diff_s) begin
            decided_r <= 1'b1;
            lt_r      <= chunk_lt_s;
            gt_r      <= chunk_gt_s;
          end
          if (exit_s) begin
            state_r      <= DONE;
            o_valid      <= 1'b1;
            equals       <= ~(decided_r | diff_s);
            less_than    <= res_lt_s;
            greater_than <= res_gt_s;
          end else begin
            idx_r <= idx_r - CW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            state_r      <= IDLE;
            o_valid      <= 1'b0;
            equals       <= 1'b0;
            less_than    <= 1'b0;
            greater_than <= 1'b0;
            o_ready      <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          o_ready      <= 1'b1;
          o_valid      <= 1'b0;
          equals       <= 1'b0;
          less_than    <= 1'b0;
          greater_than <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_seq.sv
// Randomized bench for comparator_seq against an arithmetic reference model (three geometries).
module tb_comparator_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iv = 3'b000;
  logic [2:0]  ir = 3'b111;
  logic [2:0]  sm = 3'b000;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic [63:0] a64 = 64'd0, b64 = 64'd0;
  wire  [2:0]  ordy, ovld, eq, lt, gt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  comparator_seq #(.N(32), .W(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[0]), .o_ready(ordy[0]), .a(a32), .b(b32),
    .signed_mode(sm[0]), .o_valid(ovld[0]), .i_ready(ir[0]),
    .equals(eq[0]), .less_than(lt[0]), .greater_than(gt[0]));

  comparator_seq #(.N(16), .W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[1]), .o_ready(ordy[1]), .a(a16), .b(b16),
    .signed_mode(sm[1]), .o_valid(ovld[1]), .i_ready(ir[1]),
    .equals(eq[1]), .less_than(lt[1]), .greater_than(gt[1]));

  comparator_seq #(.N(64), .W(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .i_valid(iv[2]), .o_ready(ordy[2]), .a(a64), .b(b64),
    .signed_mode(sm[2]), .o_valid(ovld[2]), .i_ready(ir[2]),
    .equals(eq[2]), .less_than(lt[2]), .greater_than(gt[2]));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbits(input int inst);
    return (inst == 0) ? 32 : (inst == 1) ? 16 : 64;
  endfunction

  function automatic int wbits(input int inst);
    return (inst == 0) ? 8 : (inst == 1) ? 16 : 4;
  endfunction

  function automatic logic [63:0] mask_of(input int n);
    return (n >= 64) ? {64{1'b1}} : ((64'd1 << n) - 64'd1);
  endfunction

  // Status word {o_ready, o_valid, equals, less_than, greater_than}.
  function automatic logic [4:0] st(input int inst);
    return {ordy[inst], ovld[inst], eq[inst], lt[inst], gt[inst]};
  endfunction

  // Reference: operands as mathematical integers, compared directly. Returns {eq, lt, gt}.
  function automatic logic [2:0] ref_cmp(input int n, input logic [63:0] av, input logic [63:0] bv,
                                         input logic smv);
    logic [63:0] am, bm;
    logic signed [65:0] sa, sb;
    am = av & mask_of(n);
    bm = bv & mask_of(n);
    sa = $signed({2'b00, am});
    sb = $signed({2'b00, bm});
    if (smv && am[n-1]) sa = sa - (66'sd1 <<< n);
    if (smv && bm[n-1]) sb = sb - (66'sd1 <<< n);
    return {sa == sb, sa < sb, sa > sb};
  endfunction

  // Latency in cycles from acceptance edge to o_valid.
  function automatic int exp_lat(input int n, input int w, input logic [63:0] av, input logic [63:0] bv);
    logic [63:0] x;
    int c;
    c = n / w;
    x = (av ^ bv) & mask_of(n);
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    for (int h = n - 1; h >= 0; h--) begin
      if (x[h]) return c - h / w;
    end
`else
    if (x == 64'd0) return c;
`endif
    return c;
  endfunction

  task automatic drive_ops(input int inst, input logic [63:0] av, input logic [63:0] bv);
    case (inst)
      0: begin a32 = av[31:0]; b32 = bv[31:0]; end
      1: begin a16 = av[15:0]; b16 = bv[15:0]; end
      default: begin a64 = av; b64 = bv; end
    endcase
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic run_txn(input int inst, input logic [63:0] av, input logic [63:0] bv,
                         input logic smv, input bit hold);
    logic [2:0] exp;
    logic [4:0] s, s0;
    int lat, elat;
    exp  = ref_cmp(nbits(inst), av, bv, smv);
    elat = exp_lat(nbits(inst), wbits(inst), av, bv);
    @(negedge clk);
    drive_ops(inst, av, bv);
    sm[inst] = smv;
    iv[inst] = 1'b1;
    ir[inst] = hold ? 1'b0 : 1'b1;
    s = st(inst);
    check_val("ready_idle", {63'd0, s[4]}, 64'd1);
    @(posedge clk);
    #1;
    iv[inst] = 1'b0;
    drive_ops(inst, rnd64(), rnd64());
    sm[inst] = ~smv;
    s = st(inst);
    check_val("ready_busy", {63'd0, s[4]}, 64'd0);
    lat = 0;
    while (!s[3] && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      s = st(inst);
    end
    check_val("latency", 64'(lat), 64'(elat));
    check_val("result", {61'd0, s[2:0]}, {61'd0, exp});
    if (hold) begin
      s0 = s;
      repeat (3) begin
        @(negedge clk);
        drive_ops(inst, rnd64(), rnd64());
        iv[inst] = 1'b1;
        @(posedge clk);
        #1;
        check_val("hold_stable", {59'd0, st(inst)}, {59'd0, 1'b0, 1'b1, exp});
      end
      @(negedge clk);
      iv[inst] = 1'b0;
      ir[inst] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_val("release", {59'd0, st(inst)}, {59'd0, 5'b10000});
  endtask

  initial begin
    logic [63:0] av, bv;
    int n;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_val("reset", {59'd0, st(i)}, {59'd0, 5'b10000});
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(0, 64'h0, 64'h0, 1'b0, 1'b0);
    run_txn(0, 64'hFFFFFFFF, 64'h00000001, 1'b1, 1'b0);
    run_txn(0, 64'hFFFFFFFF, 64'h00000001, 1'b0, 1'b0);
    run_txn(0, 64'hAE68305C, 64'h23907547, 1'b1, 1'b0);
    run_txn(0, 64'hAE68305C, 64'h23907547, 1'b0, 1'b0);
    run_txn(0, 64'h12345678, 64'h12345679, 1'b0, 1'b0);
    run_txn(0, 64'h80000000, 64'h7FFFFFFF, 1'b1, 1'b1);
    run_txn(1, 64'h8000, 64'h7FFF, 1'b1, 1'b0);
    run_txn(2, 64'h8000000000000000, 64'h0, 1'b1, 1'b0);

    // Abort mid-compare: after one compare edge, two chunks remain beyond the current one.
    @(negedge clk);
    drive_ops(0, 64'h12345678, 64'h12345679);
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_reset", {59'd0, st(0)}, {59'd0, 5'b10000});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check_val("no_stale_valid", {59'd0, st(0)}, {59'd0, 5'b10000});
    end
    run_txn(0, 64'h12345678, 64'h12345679, 1'b0, 1'b0);

    for (int i = 0; i < 1300; i++) begin
      int inst;
      inst = (i < 1000) ? 0 : (i < 1150) ? 1 : 2;
      n  = nbits(inst);
      av = rnd64() & mask_of(n);
      case ($urandom_range(0, 3))
        0:       bv = av;
        1:       bv = av ^ (64'd1 << $urandom_range(0, n - 1));
        default: bv = rnd64() & mask_of(n);
      endcase
      run_txn(inst, av, bv, 1'($urandom_range(0, 1)), (i % 97) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
